// File: rtl/config_store_unit.sv
// Configuration store: holds the active config, a circular undo history,
// and a handshaked read-out stream (active config, then history newest first).
module config_store_unit #(
  parameter int         DEPTH     = 4,
  parameter int         CW        = 3,
  parameter logic [1:0] RESET_KEY = 2'b00
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          write_en,
  input  logic [34:0]   configin,
  input  logic          undo,
  output logic [1:0]    syskey,
  output logic [34:0]   active_config,
  output logic [CW-1:0] hist_count,
  output logic          undo_err,
  input  logic          rd_req,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [34:0]   rd_data,
  output logic          rd_last,
  output logic          rd_abort
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} rd_state_t;

  logic          r_write_d, r_undo_d, r_rd_req_d;
  logic [34:0]   r_active_config;
  logic [34:0]   r_hist_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_hist_count;
  logic          r_undo_err;

  rd_state_t     r_state, w_state_next;
  logic [CW-1:0] r_rd_idx, w_rd_idx_next;
  logic [CW-1:0] r_rd_n, w_rd_n_next;
  logic          r_rd_valid, w_rd_valid_next;
  logic [34:0]   r_rd_data, w_rd_data_next;
  logic          r_rd_last, w_rd_last_next;
  logic          r_rd_abort, w_rd_abort_next;

  logic          w_write_edge, w_undo_edge, w_rd_req_edge;
  logic          w_undo_ok, w_hist_full;
  logic [PW-1:0] w_top_addr, w_rd_addr;
  logic [CW-1:0] w_idx_inc;

  assign w_write_edge  = write_en & ~r_write_d;
  assign w_undo_edge   = undo & ~r_undo_d;
  assign w_rd_req_edge = rd_req & ~r_rd_req_d;
  assign w_hist_full   = (r_hist_count == CW'(DEPTH));
  // A simultaneous write wins; the undo is then reported as rejected.
  assign w_undo_ok     = w_undo_edge & ~w_write_edge & (r_hist_count != '0);
  assign w_top_addr    = r_wr_ptr - PW'(1);
  assign w_idx_inc     = r_rd_idx + CW'(1);
  // Word k of a dump is k entries below the write pointer (wraps mod DEPTH).
  assign w_rd_addr     = r_wr_ptr - PW'(w_idx_inc);

  always_ff @(posedge clk) begin
    if (arst) begin
      r_write_d  <= 1'b0;
      r_undo_d   <= 1'b0;
      r_rd_req_d <= 1'b0;
    end else begin
      r_write_d  <= write_en;
      r_undo_d   <= undo;
      r_rd_req_d <= rd_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst && w_write_edge) begin
      r_hist_mem[r_wr_ptr] <= r_active_config;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_active_config <= {RESET_KEY, 33'b0};
      r_wr_ptr        <= '0;
      r_hist_count    <= '0;
      r_undo_err      <= 1'b0;
    end else begin
      r_undo_err <= w_undo_edge & ~w_undo_ok;
      if (w_write_edge) begin
        r_active_config <= configin;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
        if (!w_hist_full) begin
          r_hist_count <= r_hist_count + CW'(1);
        end
      end else if (w_undo_ok) begin
        r_active_config <= r_hist_mem[w_top_addr];
        r_wr_ptr        <= w_top_addr;
        r_hist_count    <= r_hist_count - CW'(1);
      end
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_rd_idx_next   = r_rd_idx;
    w_rd_n_next     = r_rd_n;
    w_rd_valid_next = r_rd_valid;
    w_rd_data_next  = r_rd_data;
    w_rd_last_next  = r_rd_last;
    w_rd_abort_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A dump request coinciding with a state change is dropped so the
        // snapshot never straddles an update.
        if (w_rd_req_edge && !w_write_edge && !w_undo_edge) begin
          w_state_next    = S_SEND;
          w_rd_idx_next   = '0;
          w_rd_n_next     = r_hist_count;
          w_rd_valid_next = 1'b1;
          w_rd_data_next  = r_active_config;
          w_rd_last_next  = (r_hist_count == '0);
        end
      end
      S_SEND: begin
        if (w_write_edge || w_undo_edge) begin
          w_state_next    = S_IDLE;
          w_rd_valid_next = 1'b0;
          w_rd_last_next  = 1'b0;
          w_rd_abort_next = 1'b1;
        end else if (r_rd_valid && rd_ready) begin
          if (r_rd_last) begin
            w_state_next    = S_IDLE;
            w_rd_valid_next = 1'b0;
            w_rd_last_next  = 1'b0;
          end else begin
            w_rd_idx_next  = w_idx_inc;
            w_rd_data_next = r_hist_mem[w_rd_addr];
            w_rd_last_next = (w_idx_inc == r_rd_n);
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state    <= S_IDLE;
      r_rd_idx   <= '0;
      r_rd_n     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_rd_abort <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rd_idx   <= w_rd_idx_next;
      r_rd_n     <= w_rd_n_next;
      r_rd_valid <= w_rd_valid_next;
      r_rd_data  <= w_rd_data_next;
      r_rd_last  <= w_rd_last_next;
      r_rd_abort <= w_rd_abort_next;
    end
  end

  assign syskey        = r_active_config[34:33];
  assign active_config = r_active_config;
  assign hist_count    = r_hist_count;
  assign undo_err      = r_undo_err;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rd_last       = r_rd_last;
  assign rd_abort      = r_rd_abort;

endmodule

// File: tb/tb_config_store_unit.sv
// Randomized bench for config_store_unit: queue/array reference model for the
// configuration state, scoreboard plus independent monitor for the dump stream.
module tb_config_store_unit;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          arst, write_en, undo, rd_req, rd_ready;
  logic [34:0]   configin;
  logic [1:0]    syskey;
  logic [34:0]   active_config;
  logic [CW-1:0] hist_count;
  logic          undo_err, rd_valid, rd_last, rd_abort;
  logic [34:0]   rd_data;

  config_store_unit #(.DEPTH(DEPTH), .CW(CW), .RESET_KEY(2'b00)) dut (
    .clk(clk), .arst(arst), .write_en(write_en), .configin(configin),
    .undo(undo), .syskey(syskey), .active_config(active_config),
    .hist_count(hist_count), .undo_err(undo_err), .rd_req(rd_req),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_abort(rd_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        last;
    logic [34:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [34:0] m_active;
  logic [34:0] m_hist[$];   // back = newest
  int          total = 0;
  int          bad   = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(string nm);
    chk({nm, "_active"}, 64'(active_config), 64'(m_active));
    chk({nm, "_syskey"}, 64'(syskey), 64'(m_active[34:33]));
    chk({nm, "_count"}, 64'(hist_count), 64'(m_hist.size()));
  endtask

  function automatic void model_write(logic [34:0] v);
    m_hist.push_back(m_active);
    if (m_hist.size() > DEPTH) m_hist.delete(0);
    m_active = v;
  endfunction

  task automatic do_write(logic [34:0] v);
    $display("txn write %h", v);
    configin = v;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
    model_write(v);
    chk_state("write");
    tick();
  endtask

  task automatic do_undo();
    logic exp_err;
    exp_err = (m_hist.size() == 0);
    $display("txn undo (expect err=%0d)", exp_err);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    if (!exp_err) m_active = m_hist.pop_back();
    chk("undo_err", 64'(undo_err), 64'(exp_err));
    chk_state("undo");
    tick();
    chk("undo_err_pulse", 64'(undo_err), 64'(0));
  endtask

  // Dump with rd_ready taken from pattern bits (LSB first) or random when rnd.
  task automatic do_dump(logic [15:0] pat, bit rnd);
    int n, c;
    n = m_hist.size();
    $display("txn dump words=%0d", n + 1);
    exp_q.push_back({(n == 0), m_active});
    for (int k = 1; k <= n; k++) exp_q.push_back({(k == n), m_hist[n - k]});
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    c = 0;
    while (exp_q.size() > 0 && c < 60) begin
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : pat[c % 16];
      tick();
      c++;
    end
    rd_ready = 1'b0;
    if (exp_q.size() > 0) begin
      chk("dump_timeout", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    chk("dump_valid_drop", 64'(rd_valid), 64'(0));
  endtask

  // Monitor: pops on each transfer and checks hold stability while stalled.
  logic        mon_stalled = 1'b0;
  logic [34:0] mon_held;
  always @(negedge clk) begin
    if (!arst && rd_valid) begin
      if (mon_stalled) chk("hold_data", 64'(rd_data), 64'(mon_held));
      if (rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 64'(rd_data), 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("txn rd word %h last=%0d", rd_data, rd_last);
          chk("rd_data", 64'(rd_data), 64'(e.data));
          chk("rd_last", 64'(rd_last), 64'(e.last));
        end
      end
      mon_stalled = !rd_ready;
      mon_held    = rd_data;
    end else begin
      mon_stalled = 1'b0;
    end
  end

  logic [34:0] w_a, w_b, v;
  int          base;

  initial begin
    arst = 1'b1; write_en = 1'b0; undo = 1'b0; rd_req = 1'b0; rd_ready = 1'b0;
    configin = '0;
    m_active = '0;
    repeat (3) tick();
    arst = 1'b0;
    repeat (3) tick();
    chk_state("reset");
    chk("reset_rd_valid", 64'(rd_valid), 64'(0));
    chk("reset_undo_err", 64'(undo_err), 64'(0));

    w_a = {2'b10, 33'h1_2345_6789};
    w_b = {2'b01, 33'h0_0000_00FF};
    do_write(w_a);
    do_write(w_b);
    do_undo();

    for (int i = 1; i <= 6; i++) do_write({2'(i), 33'(i * 32'h1111)});
    for (int i = 0; i < 5; i++) do_undo();

    do_write(35'h2_0000_0001);
    do_write(35'h5_ABCD_0002);
    do_dump(16'b1101, 1'b0);

    // Simultaneous write and undo edges.
    $display("txn write+undo");
    configin = 35'h7_0F0F_0F0F;
    write_en = 1'b1;
    undo     = 1'b1;
    tick();
    write_en = 1'b0;
    undo     = 1'b0;
    model_write(35'h7_0F0F_0F0F);
    chk("wu_undo_err", 64'(undo_err), 64'(1));
    chk_state("wu");
    tick();

    // Abort mid-dump: first word taken, second pending, then a write edge.
    $display("txn dump-abort");
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    exp_q.push_back({1'b0, m_active});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    tick();
    chk("abort_pending_valid", 64'(rd_valid), 64'(1));
    configin = 35'h3_1357_9BDF;
    write_en = 1'b1;
    tick();
    write_en = 1'b0;
    model_write(35'h3_1357_9BDF);
    chk("abort_pulse", 64'(rd_abort), 64'(1));
    chk("abort_valid", 64'(rd_valid), 64'(0));
    chk_state("abort");
    tick();
    chk("abort_pulse_end", 64'(rd_abort), 64'(0));
    chk("abort_drained", 64'(exp_q.size()), 64'(0));
    exp_q.delete();

    // Level held high commits once.
    $display("txn write held 5 cycles");
    configin = 35'h1_AAAA_5555;
    write_en = 1'b1;
    repeat (5) tick();
    write_en = 1'b0;
    model_write(35'h1_AAAA_5555);
    tick();
    chk_state("held");

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      base = $urandom_range(0, 9);
      if (base < 4) begin
        v = {3'($urandom), 32'($urandom)};
        do_write(v);
      end else if (base < 7) begin
        do_undo();
      end else begin
        do_dump(16'h0, 1'b1);
      end
    end

    // Empty-history dump is a single word with rd_last.
    while (m_hist.size() > 0) do_undo();
    do_dump(16'hFFFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
